// File: rtl/input_status_monitor.sv
// rtl/input_status_monitor.sv - synchronise, debounce and timestamp-queue status word changes
//
// Purpose:
//   Two-flop synchronises each bit of the upstream status word, debounces it
//   with a per-bit counter, and queues one event per change of the debounced
//   word into a show-ahead FIFO drained through a valid/ready handshake.
//
// Optional feature macro: STATUS_MON_TIMESTAMP_EN
//   defined   : free-running timestamp counter is built, evt_time carries the
//               timestamp captured when the change was queued.
//   undefined : no counter and no timestamp storage; evt_time is tied to 0.
//
// Ports:
//   sysclk         in   system clock, all logic on rising edge
//   reset          in   synchronous active-high reset
//   status_in      in   raw status word from the upstream stage
//   enable         in   1 = queue change events, 0 = debounce only
//   evt_ready      in   consumer accepts the head event
//   clr_overflow   in   clears the sticky overflow flag
//   stable_status  out  debounced status word
//   evt_valid      out  FIFO non-empty, head event presented
//   evt_status     out  debounced word after the change
//   evt_mask       out  bits that changed (old XOR new)
//   evt_time       out  timestamp of the change
//   fifo_count     out  entries held
//   overflow       out  sticky: an event was dropped

module input_status_monitor #(
  parameter int WIDTH      = 9,
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              status_in,
  input  logic                          enable,
  input  logic                          evt_ready,
  input  logic                          clr_overflow,
  output logic [WIDTH-1:0]              stable_status,
  output logic                          evt_valid,
  output logic [WIDTH-1:0]              evt_status,
  output logic [WIDTH-1:0]              evt_mask,
  output logic [TS_WIDTH-1:0]           evt_time,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // A single-cycle debounce still needs a 1-bit counter to keep the vector legal.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEB_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  // ------------------------------------------------------------------
  // Synchroniser
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= status_in;
      s2 <= s1;
    end
  end

  // ------------------------------------------------------------------
  // Debounce
  // ------------------------------------------------------------------
  logic [CW-1:0]    cnt_q    [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] flip;

  // A bit flips only once the synchronised value has disagreed with the
  // debounced value for DEB_CYCLES consecutive edges; any agreement restarts
  // the count, so short glitches never leak through.
  always_comb begin
    stable_next = stable_q;
    flip        = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_next[i] = s2[i];
          flip[i]        = 1'b1;
        end else begin
          cnt_next[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_next[i];
      end
    end
  end

  assign stable_status = stable_q;

  // ------------------------------------------------------------------
  // Timestamp
  // ------------------------------------------------------------------
`ifdef STATUS_MON_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  // Free-running; wraps silently.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end
`endif

  // ------------------------------------------------------------------
  // Event FIFO
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] mem_status [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_mask   [FIFO_DEPTH];
`ifdef STATUS_MON_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] mem_time [FIFO_DEPTH];
`endif

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_COUNT);
  assign push_req = enable && (|flip);
  assign pop      = !empty && evt_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A drop on the same edge as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage needs no reset: outputs are gated by evt_valid below.
  always_ff @(posedge sysclk) begin
    if (push) begin
      mem_status[wr_ptr] <= stable_next;
      mem_mask[wr_ptr]   <= flip;
`ifdef STATUS_MON_TIMESTAMP_EN
      mem_time[wr_ptr]   <= ts_q;
`endif
    end
  end

  assign evt_valid  = !empty;
  assign fifo_count = count_q;
  assign evt_status = evt_valid ? mem_status[rd_ptr] : '0;
  assign evt_mask   = evt_valid ? mem_mask[rd_ptr]   : '0;
`ifdef STATUS_MON_TIMESTAMP_EN
  assign evt_time   = evt_valid ? mem_time[rd_ptr]   : '0;
`else
  assign evt_time   = '0;
`endif

endmodule

// File: doc/input_status_monitor.md
Name: input_status_monitor

Overview:
Downstream consumer of the 9-bit input_status word driven by the status-driver stage. It synchronises and debounces each bit, and detects changes in the debounced word. Each change is queued as a timestamped event in a small FIFO, which the host/sequencer logic drains through a valid/ready handshake.

Parameters:
WIDTH, 9, status word width (matches input_status)
DEB_CYCLES, 4, consecutive cycles a synchronised bit must differ before the debounced bit flips (>=1)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
TS_WIDTH, 16, timestamp counter width

Ports:
sysclk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
status_in  in  WIDTH  raw status word (input_status from upstream stage)
enable  in  1  1 = capture events; 0 = debounce runs, no FIFO pushes
evt_ready  in  1  consumer accepts head event
clr_overflow  in  1  clears sticky overflow
stable_status  out  WIDTH  debounced status word
evt_valid  out  1  FIFO non-empty, head event presented
evt_status  out  WIDTH  debounced word after the change
evt_mask  out  WIDTH  bits that changed (old XOR new)
evt_time  out  TS_WIDTH  timestamp of the change
fifo_count  out  log2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset (reset=1 at a rising edge):
  - sync flops, debounce counters, stable_status, timestamp, FIFO pointers, fifo_count, overflow all go to 0.
  - evt_valid=0; evt_status/evt_mask/evt_time=0.
  - Reset mid-operation discards queued events.
- Synchroniser: 2-flop chain per bit, s1 then s2.
- Debounce, per bit i, each edge:
  - s2[i]==stable[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i]==DEB_CYCLES-1: stable[i] <= s2[i] and cnt[i] <= 0.
  - Otherwise cnt[i] <= cnt[i]+1.
  - Glitches shorter than DEB_CYCLES sampled cycles never reach stable_status.
- Latency: status_in first sampled new at edge 1 and held → stable_status updates at edge 2+DEB_CYCLES (DEB_CYCLES=4: edge 6).
- Change detect:
  - If any stable bit updates at an edge and enable=1, one event is pushed at that same edge: {new stable word, XOR mask, current timestamp}.
  - Several bits flipping at the same edge produce one event.
- Timestamp: free-running, increments every cycle out of reset, wraps all-ones → 0 without a flag.
- FIFO:
  - Show-ahead; evt_valid = (fifo_count!=0).
  - evt_valid goes high the cycle after the push edge.
  - Pop when evt_valid & evt_ready at an edge.
  - Outputs stable while evt_valid=1 and evt_ready=0.
- Boundaries:
  - Push+pop same edge: count unchanged; both succeed even when full.
  - Full + push without pop: event dropped, overflow <= 1, FIFO contents unchanged.
  - Pop when empty: ignored.
  - clr_overflow and a drop at the same edge: overflow stays 1 (set wins).
- enable=0: stable_status still tracks; changes not queued; FIFO drains normally.

Optional Feature:
Macro STATUS_MON_TIMESTAMP_EN.
- Defined: timestamp counter built; evt_time carries the captured timestamp.
- Undefined: no counter or FIFO timestamp storage; evt_time tied to 0; all other behaviour identical.

Test Plan:
1. Reset, status_in=0 → stable_status=0, evt_valid=0, fifo_count=0, overflow=0.
2. status_in 0→9'h005 held, evt_ready=1, DEB_CYCLES=4:
   - stable_status=9'h005 after edge 6.
   - One event: evt_status=9'h005, evt_mask=9'h005, evt_time=value at edge 6 (timestamp macro on).
3. Bit 3 pulsed high for 3 cycles then low → stable_status unchanged, no event.
4. evt_ready=0, toggle bit 0 ten times (each held 6 cycles):
   - fifo_count saturates at 8, overflow=1.
   - Draining yields 8 events, alternating evt_status 9'h001/9'h000.
   - clr_overflow → overflow=0.
5. FIFO full, evt_ready=1 on the same edge as a new change → count stays 8, overflow stays 0, new event appears last.
6. enable=0 during a change 9'h000→9'h1FF → stable_status=9'h1FF, no event queued; reset asserted with 3 queued events → fifo_count=0 next cycle.
